// File: rtl/dp_pkg.sv
// Shared definitions for the start/count/flag datapath: counter width,
// status bit positions and the captured per-run result layout.
package dp_pkg;

    localparam int unsigned A_W    = 4;
    localparam int unsigned A2_IDX = 2;
    localparam int unsigned A3_IDX = 3;
    localparam int unsigned RES_W  = A_W + 1;

    // Result captured at end of run: E in the MSB, counter A below it.
    typedef struct packed {
        logic           e;
        logic [A_W-1:0] a;
    } dp_result_t;

    function automatic dp_result_t make_result(input logic e, input logic [A_W-1:0] a);
        dp_result_t r;
        r.e = e;
        r.a = a;
        return r;
    endfunction

endpackage

// File: rtl/dp_strobe_chk.sv
// Illegal control-strobe detector with a sticky error flag.
// Only instantiated when DP_ERR_CHK_EN is defined.
module dp_strobe_chk
    import dp_pkg::*;
(
    input  logic clk_i,
    input  logic rst_b_i,
    input  logic set_E_i,
    input  logic clr_E_i,
    input  logic set_F_i,
    input  logic clr_A_F_i,
    input  logic incr_A_i,
    input  logic err_clr_i,
    output logic err_o
);

    logic illegal;
    logic err_d;
    logic err_q;

    // Flag conflicting strobes; a new error takes priority over the clear.
    always_comb begin
        illegal = (set_E_i   & clr_E_i)
                | (clr_A_F_i & incr_A_i)
                | (clr_A_F_i & set_F_i)
                | (set_F_i   & incr_A_i);
        err_d = err_q;
        if (illegal) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/datapath_rtl.sv
// Datapath for the start/count/flag example: 4-bit counter A, flops E and F,
// end-of-run result capture, done pulse and saturating run counter.
// Define DP_ERR_CHK_EN to enable the sticky illegal-strobe flag err_o.
module datapath_rtl
    import dp_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_b_i,
    input  logic             set_E_i,
    input  logic             clr_E_i,
    input  logic             set_F_i,
    input  logic             clr_A_F_i,
    input  logic             incr_A_i,
    input  logic             err_clr_i,
    output logic [A_W-1:0]   A_o,
    output logic             E_o,
    output logic             F_o,
    output logic             A2_o,
    output logic             A3_o,
    output logic [RES_W-1:0] result_o,
    output logic             done_o,
    output logic [CNT_W-1:0] run_cnt_o,
    output logic             err_o
);

    logic [A_W-1:0]   a_d, a_q;
    logic             e_d, e_q;
    logic             f_d, f_q;
    dp_result_t       result_d, result_q;
    logic             done_d, done_q;
    logic [CNT_W-1:0] run_cnt_d, run_cnt_q;
    logic             run_end;

    // Next-state for counter, flags and end-of-run bookkeeping.
    always_comb begin
        a_d       = a_q;
        e_d       = e_q;
        f_d       = f_q;
        result_d  = result_q;
        run_cnt_d = run_cnt_q;

        if (clr_A_F_i) begin
            a_d = '0;
        end else if (incr_A_i) begin
            a_d = a_q + 1'b1;
        end

        if (clr_A_F_i) begin
            f_d = 1'b0;
        end else if (set_F_i) begin
            f_d = 1'b1;
        end

        if (set_E_i && !clr_E_i) begin
            e_d = 1'b1;
        end else if (clr_E_i && !set_E_i) begin
            e_d = 1'b0;
        end

        // A clear in the same cycle cancels the end-of-run marker.
        run_end = set_F_i & ~clr_A_F_i;
        done_d  = run_end;
        if (run_end) begin
            result_d = make_result(e_q, a_q);
            if (run_cnt_q != '1) begin
                run_cnt_d = run_cnt_q + 1'b1;
            end
        end
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            a_q       <= '0;
            e_q       <= 1'b0;
            f_q       <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            a_q       <= a_d;
            e_q       <= e_d;
            f_q       <= f_d;
            result_q  <= result_d;
            done_q    <= done_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign A_o       = a_q;
    assign E_o       = e_q;
    assign F_o       = f_q;
    assign A2_o      = a_q[A2_IDX];
    assign A3_o      = a_q[A3_IDX];
    assign result_o  = result_q;
    assign done_o    = done_q;
    assign run_cnt_o = run_cnt_q;

`ifdef DP_ERR_CHK_EN
    dp_strobe_chk u_strobe_chk (
        .clk_i     (clk_i),
        .rst_b_i   (rst_b_i),
        .set_E_i   (set_E_i),
        .clr_E_i   (clr_E_i),
        .set_F_i   (set_F_i),
        .clr_A_F_i (clr_A_F_i),
        .incr_A_i  (incr_A_i),
        .err_clr_i (err_clr_i),
        .err_o     (err_o)
    );
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_rtl.sv
// Directed testbench for datapath_rtl. Two instances share all inputs:
// one with the default counter width and one with CNT_W=2 for saturation.
module tb_datapath_rtl;

`ifdef DP_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_b_i;
    logic       set_E_i, clr_E_i, set_F_i, clr_A_F_i, incr_A_i, err_clr_i;

    logic [3:0] A_o, A_o2;
    logic       E_o, F_o, A2_o, A3_o, done_o, err_o;
    logic       E_o2, F_o2, A2_o2, A3_o2, done_o2, err_o2;
    logic [4:0] result_o, result_o2;
    logic [7:0] run_cnt_o;
    logic [1:0] run_cnt_o2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk_i = ~clk_i;

    datapath_rtl dut (
        .clk_i(clk_i), .rst_b_i(rst_b_i),
        .set_E_i(set_E_i), .clr_E_i(clr_E_i), .set_F_i(set_F_i),
        .clr_A_F_i(clr_A_F_i), .incr_A_i(incr_A_i), .err_clr_i(err_clr_i),
        .A_o(A_o), .E_o(E_o), .F_o(F_o), .A2_o(A2_o), .A3_o(A3_o),
        .result_o(result_o), .done_o(done_o), .run_cnt_o(run_cnt_o), .err_o(err_o)
    );

    datapath_rtl #(.CNT_W(2)) dut2 (
        .clk_i(clk_i), .rst_b_i(rst_b_i),
        .set_E_i(set_E_i), .clr_E_i(clr_E_i), .set_F_i(set_F_i),
        .clr_A_F_i(clr_A_F_i), .incr_A_i(incr_A_i), .err_clr_i(err_clr_i),
        .A_o(A_o2), .E_o(E_o2), .F_o(F_o2), .A2_o(A2_o2), .A3_o(A3_o2),
        .result_o(result_o2), .done_o(done_o2), .run_cnt_o(run_cnt_o2), .err_o(err_o2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        set_E_i = 0; clr_E_i = 0; set_F_i = 0;
        clr_A_F_i = 0; incr_A_i = 0; err_clr_i = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_A"},    32'(A_o), 0);
        check({tag, "_E"},    32'(E_o), 0);
        check({tag, "_F"},    32'(F_o), 0);
        check({tag, "_A2"},   32'(A2_o), 0);
        check({tag, "_A3"},   32'(A3_o), 0);
        check({tag, "_res"},  32'(result_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_cnt"},  32'(run_cnt_o), 0);
        check({tag, "_cnt2"}, 32'(run_cnt_o2), 0);
        check({tag, "_err"},  32'(err_o), 0);
    endtask

    initial begin
        logic [3:0] exp_a;
        idle();

        // Reset values
        rst_b_i = 1'b0;
        #12;
        check_all_zero("rst");
        rst_b_i = 1'b1;

        // Start of run clears A and F
        clr_A_F_i = 1;
        step();
        clr_A_F_i = 0;
        check("clr_A", 32'(A_o), 0);
        check("clr_F", 32'(F_o), 0);
        check("clr_A2", 32'(A2_o), 0);
        check("clr_A3", 32'(A3_o), 0);
        check("clr_done", 32'(done_o), 0);

        // Walk A through a full wrap
        incr_A_i = 1;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_a = 4'(i % 16);
            check("walk_A", 32'(A_o), 32'(exp_a));
            check("walk_A2", 32'(A2_o), 32'(exp_a[2]));
            check("walk_A3", 32'(A3_o), 32'(exp_a[3]));
        end
        check("walk_done", 32'(done_o), 0);

        // Preload A=13, E=1
        for (int i = 1; i <= 13; i++) begin
            if (i == 13) set_E_i = 1;
            step();
        end
        idle();
        check("pre_A", 32'(A_o), 13);
        check("pre_E", 32'(E_o), 1);
        check("pre_A2A3", 32'({A3_o, A2_o}), 3);

        // End of run captures {E, A}
        set_F_i = 1;
        step();
        set_F_i = 0;
        check("run1_res", 32'(result_o), 32'h1D);
        check("run1_F", 32'(F_o), 1);
        check("run1_done", 32'(done_o), 1);
        check("run1_cnt", 32'(run_cnt_o), 1);
        check("run1_cnt2", 32'(run_cnt_o2), 1);
        check("run1_err", 32'(err_o), 0);
        step();
        check("run1_done_drop", 32'(done_o), 0);
        check("run1_res_hold", 32'(result_o), 32'h1D);

        // Back-to-back runs; narrow counter saturates at 3
        set_F_i = 1;
        for (int k = 2; k <= 5; k++) begin
            step();
            check("b2b_done", 32'(done_o), 1);
            check("b2b_cnt", 32'(run_cnt_o), 32'(k));
            check("b2b_cnt2", 32'(run_cnt_o2), (k > 3) ? 3 : 32'(k));
        end
        set_F_i = 0;
        step();
        check("b2b_done_drop", 32'(done_o), 0);
        check("sat_cnt2", 32'(run_cnt_o2), 3);
        check("sat_cnt", 32'(run_cnt_o), 5);

        // Conflicting E strobes hold E
        set_E_i = 1; clr_E_i = 1;
        step();
        idle();
        check("econf_E", 32'(E_o), 1);
        check("econf_err", 32'(err_o), ERR_EN ? 1 : 0);
        step();
        check("err_hold", 32'(err_o), ERR_EN ? 1 : 0);
        err_clr_i = 1;
        step();
        err_clr_i = 0;
        check("err_clr", 32'(err_o), 0);
        check("err_clr_E", 32'(E_o), 1);

        // New error beats err_clr
        set_E_i = 1; clr_E_i = 1; err_clr_i = 1;
        step();
        idle();
        check("err_win", 32'(err_o), ERR_EN ? 1 : 0);
        err_clr_i = 1;
        step();
        idle();
        check("err_clr2", 32'(err_o), 0);

        clr_E_i = 1;
        step();
        idle();
        check("clrE_E", 32'(E_o), 0);

        // clr_A_F wins over set_F: no capture
        set_F_i = 1; clr_A_F_i = 1;
        step();
        idle();
        check("clrwin_F", 32'(F_o), 0);
        check("clrwin_A", 32'(A_o), 0);
        check("clrwin_done", 32'(done_o), 0);
        check("clrwin_cnt", 32'(run_cnt_o), 5);
        check("clrwin_res", 32'(result_o), 32'h1D);
        check("clrwin_err", 32'(err_o), ERR_EN ? 1 : 0);
        err_clr_i = 1;
        step();
        idle();

        // Reset mid-run at A=6 with set_F asserted
        incr_A_i = 1;
        for (int i = 0; i < 6; i++) step();
        idle();
        check("mid_A", 32'(A_o), 6);
        check("mid_A2", 32'(A2_o), 1);
        set_F_i = 1;
        #2;
        rst_b_i = 1'b0;
        #1;
        check_all_zero("arst");
        step();
        set_F_i = 0;
        #2;
        rst_b_i = 1'b1;
        step();
        check("post_done", 32'(done_o), 0);
        check("post_cnt", 32'(run_cnt_o), 0);
        check("post_F", 32'(F_o), 0);
        step();
        check("post_done2", 32'(done_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/datapath_rtl.md
# datapath_rtl

Datapath for the start/count/flag design example. It holds a 4-bit counter A and flip-flops E and F. Each cycle it applies the one-hot-ish control strobes from the upstream controller (`ctrl_rtl`), and feeds status bits A2/A3 back to it combinationally. It also captures a per-run result, pulses completion, counts completed runs, and optionally flags illegal strobe combinations.

## Interface
Parameters:
- CNT_W, 8, width of the completed-run counter run_cnt_o

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_b_i  in  1  reset, asynchronous, active-low
- set_E_i  in  1  set E
- clr_E_i  in  1  clear E
- set_F_i  in  1  set F; marks end of run
- clr_A_F_i  in  1  clear A and F; marks start of run
- incr_A_i  in  1  increment A
- err_clr_i  in  1  synchronous clear of sticky err_o
- A_o  out  4  counter A
- E_o  out  1  flip-flop E
- F_o  out  1  flip-flop F
- A2_o  out  1  A[2], combinational from A register
- A3_o  out  1  A[3], combinational from A register
- result_o  out  5  {E, A} captured at end of run
- done_o  out  1  one-cycle completion pulse
- run_cnt_o  out  CNT_W  completed runs, saturating
- err_o  out  1  sticky illegal-strobe flag

## Operation
- Reset (async, rst_b_i=0): A=0, E=0, F=0, result_o=0, done_o=0, run_cnt_o=0, err_o=0. So A2_o=A3_o=0.
- A update, in priority order: clr_A_F_i → A=0; else incr_A_i → A=A+1 mod 16 (15→0 wraps, no flag); else hold.
- F update: clr_A_F_i → F=0 (wins over set_F_i); else set_F_i → F=1; else hold.
- E update: set_E_i & clr_E_i → hold; else set_E_i → 1; else clr_E_i → 0; else hold.
- Result capture: on a cycle with set_F_i=1 and clr_A_F_i=0:
  - result_o <= {E, A}, sampled as pre-edge register values.
  - run_cnt_o increments, saturating at 2^CNT_W−1.
  - done_o=1 for exactly the following cycle.
- done_o is registered and reflects set_F_i from the previous cycle. Back-to-back set_F_i produces back-to-back done pulses and increments.
- A2_o/A3_o have no register stage. The controller's S_1 exit test sees the current A in the same cycle.
- Reset mid-run returns all state to reset values immediately. No pending done pulse survives.

## Timing
- Strobe to register effect: 1 edge.
- set_F_i to result_o/run_cnt_o valid: 1 edge. done_o asserts in that same cycle.
- A to A2_o/A3_o: combinational, same cycle.
- err_o latency: 1 edge after the illegal cycle. err_clr_i takes effect next edge. A simultaneous new error wins over err_clr_i.

## Configuration
- DP_ERR_CHK_EN defined: err_o is set when any of the following strobe combinations occurs in a cycle:
  - set_E_i & clr_E_i
  - clr_A_F_i & incr_A_i
  - clr_A_F_i & set_F_i
  - set_F_i & incr_A_i

  err_o stays set until err_clr_i.
- DP_ERR_CHK_EN undefined:
  - err_o is tied 0 and err_clr_i is ignored.
  - Update priorities above are unchanged.

## Structure
- Package dp_pkg:
  - A_W=4, A2_IDX=2, A3_IDX=3
  - RES_W=A_W+1
  - result struct typedef {e, a}
- Sub-module dp_strobe_chk: combinational illegal-combination detector plus the sticky err register. It is instantiated only under DP_ERR_CHK_EN.

## Test plan
- Reset, then clr_A_F_i=1 one cycle → A=0, F=0, A2_o=A3_o=0, done_o stays 0.
- incr_A_i held 16 cycles from A=0 → A walks 1..15 then 0. A2_o first rises at A=4, A3_o first rises at A=8, and both are 1 at A=12.
- Preload via incr to A=13, E=1, then set_F_i=1 → next cycle: result_o=5'b1_1101, F_o=1, done_o=1 for one cycle, run_cnt_o=1.
- CNT_W=2, four set_F_i runs → run_cnt_o=3 and held; done_o pulses 4 times.
- set_E_i & clr_E_i with E=1 → E stays 1. With DP_ERR_CHK_EN: err_o=1 next cycle, holds, clears after err_clr_i. Without it: err_o stays 0.
- rst_b_i pulsed low mid-run at A=6 with set_F_i asserted → all outputs 0 asynchronously, and no done_o after release.
